led_seq_ctrl: RTL and testbench

//   Pattern sequencer driving the 2-bit select {in1,in0} of the 4-LED one-hot decoder.

---
 rtl/led_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps a 2-bit decoder select up, down or back-and-forth
// at a prescaled rate, with a synchronized push button that cycles the mode.
module led_seq_ctrl #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  input  logic       mode_btn,
  output logic [1:0] sel,
  output logic [1:0] mode,
  output logic       tick,
  output logic       busy
);

  typedef enum logic [1:0] {
    MODE_UP  = 2'd0,
    MODE_DN  = 2'd1,
    MODE_BNC = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_UP = 3'd1,
    S_DN = 3'd2,
    S_BU = 3'd3,
    S_BD = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic             sync1_q, sync2_q, edge_q;
  logic             mode_adv;
  mode_e            mode_q, mode_d;
  state_e           state_q, entry_state, step_state;
  logic [1:0]       sel_q, step_sel;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q, busy_q;
  logic             terminal;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= mode_btn;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign mode_adv = sync2_q & ~edge_q;
  assign terminal = (cnt_q == CNT_MAX);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      case (mode_q)
        MODE_UP: mode_d = MODE_DN;
        MODE_DN: mode_d = MODE_BNC;
        default: mode_d = MODE_UP;
      endcase
    end
  end

  // State to enter for the (possibly just-changed) mode; bounce picks its
  // direction so a select already at the top end starts by falling.
  always_comb begin
    entry_state = S_BU;
    case (mode_d)
      MODE_UP: entry_state = S_UP;
      MODE_DN: entry_state = S_DN;
      default: entry_state = (sel_q == 2'd3) ? S_BD : S_BU;
    endcase
  end

  always_comb begin
    step_sel   = sel_q;
    step_state = state_q;
    case (state_q)
      S_UP: step_sel = sel_q + 2'd1;
      S_DN: step_sel = sel_q - 2'd1;
      S_BU: begin
        step_sel = sel_q + 2'd1;
        if (sel_q == 2'd2) step_state = S_BD;
      end
      S_BD: begin
        step_sel = sel_q - 2'd1;
        if (sel_q == 2'd1) step_state = S_BU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q <= 2'd0;
          cnt_q <= '0;
          if (run) begin
            state_q <= entry_state;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (!run) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (mode_adv) begin
            // A mode change pre-empts any coincident step and restarts the interval.
            state_q <= entry_state;
            cnt_q   <= '0;
          end else if (!hold) begin
            if (terminal) begin
              cnt_q   <= '0;
              tick_q  <= 1'b1;
              sel_q   <= step_sel;
              state_q <= step_state;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign mode = mode_q;
  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with PRESCALE=4: expected select values are
// queued as each phase is driven and compared when the DUT raises tick.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic       hold;
  logic       mode_btn;
  logic [1:0] sel;
  logic [1:0] mode;
  logic       tick;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  led_seq_ctrl #(
    .PRESCALE(4),
    .CNT_W   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .hold    (hold),
    .mode_btn(mode_btn),
    .sel     (sel),
    .mode    (mode),
    .tick    (tick),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next tick, then checks latency and popped select.
  task automatic wait_tick(input string tag, input int exp_cycles);
    int         cycles = 0;
    logic [1:0] exp_sel;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < 20);
    exp_sel = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    check({tag, " tick"}, 32'(tick), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(exp_cycles));
    check({tag, " sel"}, 32'(sel), 32'(exp_sel));
  endtask

  task automatic press_btn();
    mode_btn = 1'b1;
    repeat (3) @(negedge clk);
    mode_btn = 1'b0;
  endtask

  initial begin
    int tick_seen;
    int sel_bad;
    int busy_bad;

    rst = 1'b0; run = 1'b0; hold = 1'b0; mode_btn = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset sel", 32'(sel), 32'd0);
    check("reset mode", 32'(mode), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // UP: first tick 4 edges after run is sampled
    run = 1'b1;
    @(negedge clk);
    check("up busy", 32'(busy), 32'd1);
    check("up sel start", 32'(sel), 32'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int i = 0; i < 4; i++) wait_tick("up", 4);

    // Back to IDLE, then one press selects DOWN (3 edges after the press)
    run = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle sel", 32'(sel), 32'd0);
    mode_btn = 1'b1;
    @(negedge clk);
    check("dn mode e1", 32'(mode), 32'd0);
    @(negedge clk);
    check("dn mode e2", 32'(mode), 32'd0);
    @(negedge clk);
    check("dn mode e3", 32'(mode), 32'd1);
    mode_btn = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("dn busy", 32'(busy), 32'd1);
    exp_q.push_back(2'd3); exp_q.push_back(2'd2);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    for (int i = 0; i < 4; i++) wait_tick("dn", 4);

    // BOUNCE
    run = 1'b0;
    @(negedge clk);
    press_btn();
    check("bnc mode", 32'(mode), 32'd2);
    repeat (3) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int i = 0; i < 7; i++) begin
      wait_tick("bnc", 4);
      check("bnc busy", 32'(busy), 32'd1);
    end

    // Hold mid-interval (count at 2) for 10 cycles
    repeat (2) @(negedge clk);
    hold = 1'b1;
    tick_seen = 0;
    sel_bad   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick !== 1'b0) tick_seen++;
      if (sel !== 2'd1) sel_bad++;
    end
    check("hold ticks", 32'(tick_seen), 32'd0);
    check("hold sel changes", 32'(sel_bad), 32'd0);
    hold = 1'b0;
    exp_q.push_back(2'd2);
    wait_tick("hold release", 2);

    // UP to sel=3, then a mode change landing on the terminal-count edge
    run = 1'b0;
    @(negedge clk);
    press_btn();
    check("up2 mode", 32'(mode), 32'd0);
    repeat (3) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    for (int i = 0; i < 3; i++) wait_tick("up2", 4);
    @(negedge clk);
    mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("adv pre mode", 32'(mode), 32'd0);
    check("adv pre tick", 32'(tick), 32'd0);
    @(negedge clk);
    check("adv mode", 32'(mode), 32'd1);
    check("adv sel", 32'(sel), 32'd3);
    check("adv tick", 32'(tick), 32'd0);
    mode_btn = 1'b0;
    exp_q.push_back(2'd2);
    wait_tick("adv next", 4);

    // Active switch DOWN->BOUNCE at sel=2, step to 3 and back to 2
    press_btn();
    check("bnc2 mode", 32'(mode), 32'd2);
    check("bnc2 sel kept", 32'(sel), 32'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd2);
    wait_tick("bnc2", 4);
    wait_tick("bnc2", 4);

    // Asynchronous reset mid-BOUNCE, between clock edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    check("async rst sel", 32'(sel), 32'd0);
    check("async rst mode", 32'(mode), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sel_bad  = 0;
    busy_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sel !== 2'd0) sel_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    check("post rst sel", 32'(sel_bad), 32'd0);
    check("post rst busy", 32'(busy_bad), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
